axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 26 ++
 rtl/axi_rd_arbiter_if.sv | 28 ++
 rtl/axi_rd_arbiter_rd_chan_ptr.sv | 61 ++++++
 rtl/axi_rd_arbiter.sv | 129 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants for the two-channel AXI read arbiter: FSM encoding, address step, channel ids.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_rd_arbiter_pkg;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_ADDR = 3'b010;
    localparam logic [2:0] ST_DATA = 3'b100;

    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_BURST_LEN  = 16;
    localparam int BEAT_BYTES     = 8;
    localparam int DEF_ADDR_STEP  = DEF_BURST_LEN * BEAT_BYTES;

    localparam int CH_PLAYBACK   = 0;
    localparam int CH_VOICEPRINT = 1;

    // Round-robin pick: with both channels eligible the one not granted last wins.
    function automatic logic rr_pick(input logic [1:0] elig, input logic last_grant);
        if (&elig) begin
            return ~last_grant;
        end
        return elig[CH_VOICEPRINT];
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read address/data handshake bundle between the arbiter (master) and the DDR controller (slave).
// Latency: n/a (wires only).
// Backpressure: arready stalls the address phase; rvalid paces the data phase.
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 28
);
    logic              axi_arvalid;
    logic              axi_arready;
    logic [ADDR_W-1:0] axi_araddr;
    logic              axi_rvalid;
    logic              axi_rlast;

    modport master (
        output axi_arvalid,
        output axi_araddr,
        input  axi_arready,
        input  axi_rvalid,
        input  axi_rlast
    );

    modport slave (
        input  axi_arvalid,
        input  axi_araddr,
        output axi_arready,
        output axi_rvalid,
        output axi_rlast
    );
endinterface

// File: rtl/axi_rd_arbiter_rd_chan_ptr.sv
// Per-channel read cursor: pointer, end address, active flag and pending-done tracking.
// Latency: load/issue/retire take effect on the next clock; done is a registered one-cycle pulse.
// Backpressure: none; advances only on the issue strobe from the arbiter.
module rd_chan_ptr #(
    parameter int ADDR_W    = 28,
    parameter int ADDR_STEP = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              stop,
    input  logic              issue,
    input  logic              retire,
    output logic [ADDR_W-1:0] ptr,
    output logic              active,
    output logic              done
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              done_pend;

    assign ptr_nxt = ptr + STEP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            end_q     <= '0;
            active    <= 1'b0;
            done_pend <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                ptr       <= start_addr;
                end_q     <= end_addr;
                active    <= (start_addr != end_addr);
                done_pend <= 1'b0;
                done      <= (start_addr == end_addr);
            end else if (stop) begin
                active    <= 1'b0;
                done_pend <= 1'b0;
            end else if (issue) begin
                ptr <= ptr_nxt;
                // Only a still-active channel owes a done; a burst issued after stop does not.
                if (active && (ptr_nxt == end_q)) begin
                    active    <= 1'b0;
                    done_pend <= 1'b1;
                end
            end else if (retire && done_pend) begin
                done      <= 1'b1;
                done_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-channel round-robin AXI read burst arbiter (ch0 playback, ch1 voiceprint).
// Latency: AR issued one cycle after a channel becomes eligible; rvalid routed combinationally.
// Backpressure: a channel is served only with consumer space; arready holds ARVALID/ARADDR stable.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_LEN       = DEF_BURST_LEN,
    parameter int ADDR_STEP       = BURST_LEN * BEAT_BYTES
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_rd_arbiter_if.master           axi,
    input  logic                       ch0_load,
    input  logic [CTRL_ADDR_WIDTH-1:0] ch0_start_addr,
    input  logic [CTRL_ADDR_WIDTH-1:0] ch0_end_addr,
    input  logic                       ch0_stop,
    input  logic                       ch0_space,
    output logic                       ch0_active,
    output logic                       ch0_rvalid,
    output logic                       ch0_done,
    input  logic                       ch1_load,
    input  logic [CTRL_ADDR_WIDTH-1:0] ch1_start_addr,
    input  logic [CTRL_ADDR_WIDTH-1:0] ch1_end_addr,
    input  logic                       ch1_stop,
    input  logic                       ch1_space,
    output logic                       ch1_active,
    output logic                       ch1_rvalid,
    output logic                       ch1_done
);

    logic [2:0]                 state;
    logic                       owner;
    logic                       last_grant;
    logic                       arvalid_q;
    logic [CTRL_ADDR_WIDTH-1:0] araddr_q;
    logic [CTRL_ADDR_WIDTH-1:0] ptr0;
    logic [CTRL_ADDR_WIDTH-1:0] ptr1;
    logic [1:0]                 elig;
    logic                       grant;
    logic                       ar_hs;
    logic                       r_end;
    logic                       in_data;

    assign elig    = {ch1_active & ch1_space, ch0_active & ch0_space};
    assign grant   = rr_pick(elig, last_grant);
    assign ar_hs   = (state == ST_ADDR) && arvalid_q && axi.axi_arready;
    assign in_data = (state == ST_DATA);
    assign r_end   = in_data && axi.axi_rvalid && axi.axi_rlast;

    assign axi.axi_arvalid = arvalid_q;
    assign axi.axi_araddr  = araddr_q;

    // Beats follow the owner latched at grant, so a reload or stop never misroutes in-flight data.
    assign ch0_rvalid = in_data && (owner == 1'(CH_PLAYBACK))   && axi.axi_rvalid;
    assign ch1_rvalid = in_data && (owner == 1'(CH_VOICEPRINT)) && axi.axi_rvalid;

    rd_chan_ptr #(
        .ADDR_W    (CTRL_ADDR_WIDTH),
        .ADDR_STEP (ADDR_STEP)
    ) u_ch0 (
        .clk        (clk),
        .rst        (rst),
        .load       (ch0_load),
        .start_addr (ch0_start_addr),
        .end_addr   (ch0_end_addr),
        .stop       (ch0_stop),
        .issue      (ar_hs && (owner == 1'(CH_PLAYBACK))),
        .retire     (r_end && (owner == 1'(CH_PLAYBACK))),
        .ptr        (ptr0),
        .active     (ch0_active),
        .done       (ch0_done)
    );

    rd_chan_ptr #(
        .ADDR_W    (CTRL_ADDR_WIDTH),
        .ADDR_STEP (ADDR_STEP)
    ) u_ch1 (
        .clk        (clk),
        .rst        (rst),
        .load       (ch1_load),
        .start_addr (ch1_start_addr),
        .end_addr   (ch1_end_addr),
        .stop       (ch1_stop),
        .issue      (ar_hs && (owner == 1'(CH_VOICEPRINT))),
        .retire     (r_end && (owner == 1'(CH_VOICEPRINT))),
        .ptr        (ptr1),
        .active     (ch1_active),
        .done       (ch1_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        state      <= ST_ADDR;
                        owner      <= grant;
                        last_grant <= grant;
                        arvalid_q  <= 1'b1;
                        araddr_q   <= grant ? ptr1 : ptr0;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) begin
                        state     <= ST_DATA;
                        arvalid_q <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (r_end) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    arvalid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a small AXI read slave that answers every AR with 16 beats.
// Latency: n/a.
// Backpressure: slave arready delay is programmable per scenario.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    localparam int AW    = 28;
    localparam int BEATS = 16;

    logic clk;
    logic rst;

    axi_rd_arbiter_if #(.ADDR_W(AW)) axi ();

    logic          ch0_load, ch0_stop, ch0_space, ch0_active, ch0_rvalid, ch0_done;
    logic          ch1_load, ch1_stop, ch1_space, ch1_active, ch1_rvalid, ch1_done;
    logic [AW-1:0] ch0_start, ch0_end, ch1_start, ch1_end;

    axi_rd_arbiter #(
        .CTRL_ADDR_WIDTH (AW),
        .BURST_LEN       (BEATS),
        .ADDR_STEP       (BEATS * 8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .axi            (axi),
        .ch0_load       (ch0_load),
        .ch0_start_addr (ch0_start),
        .ch0_end_addr   (ch0_end),
        .ch0_stop       (ch0_stop),
        .ch0_space      (ch0_space),
        .ch0_active     (ch0_active),
        .ch0_rvalid     (ch0_rvalid),
        .ch0_done       (ch0_done),
        .ch1_load       (ch1_load),
        .ch1_start_addr (ch1_start),
        .ch1_end_addr   (ch1_end),
        .ch1_stop       (ch1_stop),
        .ch1_space      (ch1_space),
        .ch1_active     (ch1_active),
        .ch1_rvalid     (ch1_rvalid),
        .ch1_done       (ch1_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vec  = 0;
    int errs = 0;

    // Slave/monitor state; cleared whenever reset is low.
    int            ar_delay = 0;
    int            ar_cnt, beats0, beats1, done0, done1, route_err, stab_err, arv_cycles, wait_cycles;
    int            beats_left, wc;
    logic [AW-1:0] ar_addr[$];
    logic          last_ch;
    logic          obs_arv, obs_arr, obs_c0, obs_c1, obs_rv;
    logic [AW-1:0] obs_addr;

    // Each falling edge first accounts for the rising edge just passed, then drives the next one.
    initial begin
        axi.axi_arready = 1'b0;
        axi.axi_rvalid  = 1'b0;
        axi.axi_rlast   = 1'b0;
        last_ch = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                axi.axi_arready = 1'b0;
                axi.axi_rvalid  = 1'b0;
                axi.axi_rlast   = 1'b0;
                beats_left = 0; wc = 0;
                ar_cnt = 0; beats0 = 0; beats1 = 0; done0 = 0; done1 = 0;
                route_err = 0; stab_err = 0; arv_cycles = 0; wait_cycles = 0;
                ar_addr.delete();
                obs_arv = 1'b0; obs_arr = 1'b0; obs_c0 = 1'b0; obs_c1 = 1'b0; obs_rv = 1'b0;
                obs_addr = '0;
            end else begin
                if (ch0_done) done0++;
                if (ch1_done) done1++;
                if (obs_c0) begin beats0++; if (last_ch) route_err++; end
                if (obs_c1) begin beats1++; if (!last_ch) route_err++; end
                if (obs_rv && !obs_c0 && !obs_c1) route_err++;
                if (obs_c0 && obs_c1) route_err++;
                if (obs_rv) beats_left--;
                if (obs_arv) arv_cycles++;
                if (obs_arv && obs_arr) begin
                    ar_cnt++;
                    ar_addr.push_back(obs_addr);
                    last_ch = obs_addr[15];
                    beats_left = BEATS;
                    wc = 0;
                end else if (obs_arv) begin
                    wait_cycles++;
                    if (!axi.axi_arvalid || axi.axi_araddr != obs_addr) stab_err++;
                end
                axi.axi_rvalid = (beats_left > 0);
                axi.axi_rlast  = (beats_left == 1);
                if (axi.axi_arvalid && beats_left == 0) begin
                    if (wc >= ar_delay) axi.axi_arready = 1'b1;
                    else begin wc++; axi.axi_arready = 1'b0; end
                end else begin
                    axi.axi_arready = 1'b0;
                end
                #1;
                obs_arv  = axi.axi_arvalid;
                obs_arr  = axi.axi_arready;
                obs_addr = axi.axi_araddr;
                obs_c0   = ch0_rvalid;
                obs_c1   = ch1_rvalid;
                obs_rv   = axi.axi_rvalid;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        ch0_load = 0; ch0_stop = 0; ch0_space = 0; ch0_start = '0; ch0_end = '0;
        ch1_load = 0; ch1_stop = 0; ch1_space = 0; ch1_start = '0; ch1_end = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        ar_delay = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        vec++; if (axi.axi_arvalid !== 1'b0) begin errs++; $display("FAIL reset_arvalid got %b want 0", axi.axi_arvalid); end
        vec++; if (axi.axi_araddr !== 28'h0) begin errs++; $display("FAIL reset_araddr got %h want 0", axi.axi_araddr); end
        vec++; if ({ch1_active, ch0_active} !== 2'b00) begin errs++; $display("FAIL reset_active got %b want 00", {ch1_active, ch0_active}); end
        vec++; if ({ch1_done, ch0_done} !== 2'b00) begin errs++; $display("FAIL reset_done got %b want 00", {ch1_done, ch0_done}); end
        vec++; if ({ch1_rvalid, ch0_rvalid} !== 2'b00) begin errs++; $display("FAIL reset_rvalid got %b want 00", {ch1_rvalid, ch0_rvalid}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_zero_len();
        do_reset();
        ch0_space = 1; ch0_start = 28'h500; ch0_end = 28'h500; ch0_load = 1;
        tick();
        ch0_load = 0;
        vec++; if (ch0_done !== 1'b1) begin errs++; $display("FAIL zero_len_done got %b want 1", ch0_done); end
        vec++; if (ch0_active !== 1'b0) begin errs++; $display("FAIL zero_len_active got %b want 0", ch0_active); end
        tick();
        vec++; if (ch0_done !== 1'b0) begin errs++; $display("FAIL zero_len_done_pulse got %b want 0", ch0_done); end
        repeat (20) tick();
        vec++; if (ar_cnt !== 0) begin errs++; $display("FAIL zero_len_ar got %0d want 0", ar_cnt); end
    endtask

    task automatic test_single();
        logic [AW-1:0] exp_a [4];
        exp_a = '{28'h000, 28'h080, 28'h100, 28'h180};
        do_reset();
        ch0_space = 1; ch0_start = 28'h0; ch0_end = 28'h200; ch0_load = 1;
        tick();
        ch0_load = 0;
        for (int i = 0; i < 400 && done0 == 0; i++) tick();
        repeat (5) tick();
        vec++; if (ar_cnt !== 4) begin errs++; $display("FAIL single_ar_cnt got %0d want 4", ar_cnt); end
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] got;
            got = (i < ar_addr.size()) ? ar_addr[i] : '1;
            vec++; if (got !== exp_a[i]) begin errs++; $display("FAIL single_araddr%0d got %h want %h", i, got, exp_a[i]); end
        end
        vec++; if (beats0 !== 64) begin errs++; $display("FAIL single_beats0 got %0d want 64", beats0); end
        vec++; if (beats1 !== 0) begin errs++; $display("FAIL single_beats1 got %0d want 0", beats1); end
        vec++; if (done0 !== 1) begin errs++; $display("FAIL single_done got %0d want 1", done0); end
        vec++; if (ch0_active !== 1'b0) begin errs++; $display("FAIL single_active got %b want 0", ch0_active); end
        vec++; if (route_err !== 0) begin errs++; $display("FAIL single_route got %0d want 0", route_err); end
    endtask

    task automatic test_contention();
        logic [AW-1:0] exp_a [4];
        exp_a = '{28'h0000, 28'h8000, 28'h0080, 28'h8080};
        do_reset();
        ch0_space = 1; ch1_space = 1;
        ch0_start = 28'h0;    ch0_end = 28'h100;
        ch1_start = 28'h8000; ch1_end = 28'h8100;
        ch0_load = 1; ch1_load = 1;
        tick();
        ch0_load = 0; ch1_load = 0;
        for (int i = 0; i < 400 && (done0 == 0 || done1 == 0); i++) tick();
        repeat (5) tick();
        vec++; if (ar_cnt !== 4) begin errs++; $display("FAIL rr_ar_cnt got %0d want 4", ar_cnt); end
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] got;
            got = (i < ar_addr.size()) ? ar_addr[i] : '1;
            vec++; if (got !== exp_a[i]) begin errs++; $display("FAIL rr_araddr%0d got %h want %h", i, got, exp_a[i]); end
        end
        vec++; if (route_err !== 0) begin errs++; $display("FAIL rr_route got %0d want 0", route_err); end
        vec++; if (beats1 !== 32) begin errs++; $display("FAIL rr_beats1 got %0d want 32", beats1); end
        vec++; if ({done1, done0} !== {32'd1, 32'd1}) begin errs++; $display("FAIL rr_done got %0d/%0d want 1/1", done0, done1); end
    endtask

    task automatic test_backpressure();
        int lat;
        do_reset();
        ch0_space = 0; ch0_start = 28'h1000; ch0_end = 28'h1080; ch0_load = 1;
        tick();
        ch0_load = 0;
        repeat (50) tick();
        vec++; if (arv_cycles !== 0) begin errs++; $display("FAIL bp_arvalid_cycles got %0d want 0", arv_cycles); end
        vec++; if (ch0_active !== 1'b1) begin errs++; $display("FAIL bp_active got %b want 1", ch0_active); end
        ch0_space = 1;
        lat = 0;
        while (!axi.axi_arvalid && lat < 5) begin tick(); lat++; end
        vec++; if (lat > 2) begin errs++; $display("FAIL bp_latency got %0d want <=2", lat); end
        for (int i = 0; i < 100 && done0 == 0; i++) tick();
        vec++; if (ar_addr.size() != 1 || ar_addr[0] !== 28'h1000) begin errs++; $display("FAIL bp_araddr got %0d ARs want one at 1000", ar_addr.size()); end
        vec++; if (done0 !== 1) begin errs++; $display("FAIL bp_done got %0d want 1", done0); end
    endtask

    task automatic test_ar_delay();
        do_reset();
        ar_delay = 5;
        ch0_space = 1; ch0_start = 28'h2000; ch0_end = 28'h2080; ch0_load = 1;
        tick();
        ch0_load = 0;
        for (int i = 0; i < 100 && done0 == 0; i++) tick();
        repeat (5) tick();
        vec++; if (ar_cnt !== 1) begin errs++; $display("FAIL ardly_ar_cnt got %0d want 1", ar_cnt); end
        vec++; if (ar_addr.size() != 1 || ar_addr[0] !== 28'h2000) begin errs++; $display("FAIL ardly_araddr got %0d ARs want one at 2000", ar_addr.size()); end
        vec++; if (wait_cycles !== 5) begin errs++; $display("FAIL ardly_wait got %0d want 5", wait_cycles); end
        vec++; if (stab_err !== 0) begin errs++; $display("FAIL ardly_stable got %0d want 0", stab_err); end
        vec++; if (done0 !== 1) begin errs++; $display("FAIL ardly_done got %0d want 1", done0); end
    endtask

    task automatic test_stop();
        do_reset();
        ch1_space = 1; ch1_start = 28'h9000; ch1_end = 28'h9200; ch1_load = 1;
        tick();
        ch1_load = 0;
        for (int i = 0; i < 20 && ar_cnt == 0; i++) tick();
        ch1_stop = 1;
        tick();
        ch1_stop = 0;
        repeat (100) tick();
        vec++; if (ar_cnt !== 1) begin errs++; $display("FAIL stop_ar_cnt got %0d want 1", ar_cnt); end
        vec++; if (beats1 !== 16) begin errs++; $display("FAIL stop_beats1 got %0d want 16", beats1); end
        vec++; if (done1 !== 0) begin errs++; $display("FAIL stop_done got %0d want 0", done1); end
        vec++; if (ch1_active !== 1'b0) begin errs++; $display("FAIL stop_active got %b want 0", ch1_active); end
        vec++; if (route_err !== 0) begin errs++; $display("FAIL stop_route got %0d want 0", route_err); end
    endtask

    task automatic test_reset_in_addr();
        do_reset();
        ar_delay = 20;
        ch0_space = 1; ch0_start = 28'h3000; ch0_end = 28'h3100; ch0_load = 1;
        tick();
        ch0_load = 0;
        for (int i = 0; i < 10 && !axi.axi_arvalid; i++) tick();
        vec++; if (axi.axi_arvalid !== 1'b1) begin errs++; $display("FAIL rstaddr_pre_arvalid got %b want 1", axi.axi_arvalid); end
        rst = 1'b0;
        #1;
        vec++; if (axi.axi_arvalid !== 1'b0) begin errs++; $display("FAIL rstaddr_arvalid got %b want 0", axi.axi_arvalid); end
        vec++; if (axi.axi_araddr !== 28'h0) begin errs++; $display("FAIL rstaddr_araddr got %h want 0", axi.axi_araddr); end
        vec++; if (ch0_active !== 1'b0) begin errs++; $display("FAIL rstaddr_active got %b want 0", ch0_active); end
        tick();
        tick();
        ar_delay = 0;
        rst = 1'b1;
        repeat (30) tick();
        vec++; if (arv_cycles !== 0 || ar_cnt !== 0) begin errs++; $display("FAIL rstaddr_no_ar got %0d/%0d want 0/0", arv_cycles, ar_cnt); end
        ch0_start = 28'h3000; ch0_end = 28'h3080; ch0_load = 1;
        tick();
        ch0_load = 0;
        for (int i = 0; i < 100 && done0 == 0; i++) tick();
        vec++; if (ar_addr.size() != 1 || ar_addr[0] !== 28'h3000) begin errs++; $display("FAIL rstaddr_reload got %0d ARs want one at 3000", ar_addr.size()); end
        vec++; if (done0 !== 1) begin errs++; $display("FAIL rstaddr_done got %0d want 1", done0); end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_zero_len();
        test_single();
        test_contention();
        test_backpressure();
        test_ar_delay();
        test_stop();
        test_reset_in_addr();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
